// File: rtl/usb_serial_fifo.sv
// rtl/usb_serial_fifo.sv - TX/RX byte FIFOs between the bus-side USB registers and the usb_serial core.
module usb_serial_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GUARD      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_wr,
    input  logic [7:0]            tx_data,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  tx_overflow,
    input  logic                  rx_rd,
    output logic [7:0]            rx_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_overflow,
    input  logic                  clr_flags,
    input  logic                  uart_tx_ready,
    output logic                  uart_tx_strobe,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_rx_strobe,
    input  logic [7:0]            uart_rx_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GW    = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    localparam logic [DEPTH_LOG2:0]   LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LP_CNT1 = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] LP_PTR1 = DEPTH_LOG2'(1);
    localparam logic [GW-1:0]         LP_GUARD = GW'(GUARD);
    localparam logic [GW-1:0]         LP_G1    = GW'(1);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GUARD} tx_state_t;

    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr;
    logic [DEPTH_LOG2-1:0] r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_count;
    logic                  r_tx_overflow;
    logic [7:0]            r_uart_tx_data;
    tx_state_t             r_tx_state;
    tx_state_t             w_tx_state_next;
    logic [GW-1:0]         r_guard;
    logic [GW-1:0]         w_guard_next;
    logic                  w_tx_pop;
    logic                  w_tx_push;
    logic                  w_tx_strobe;

    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr;
    logic [DEPTH_LOG2-1:0] r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_count;
    logic                  r_rx_overflow;
    logic [7:0]            r_rx_data;
    logic                  w_rx_pop;
    logic                  w_rx_push;
    logic [DEPTH_LOG2-1:0] w_rx_head;
    logic [DEPTH_LOG2:0]   w_rx_left;

    // uart_tx_ready only matters in IDLE; the guard state lasts GUARD cycles
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_guard_next    = r_guard;
        w_tx_pop        = 1'b0;
        w_tx_strobe     = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                if (r_tx_count != '0 && uart_tx_ready) begin
                    w_tx_pop        = 1'b1;
                    w_tx_state_next = S_STROBE;
                end
            end
            S_STROBE: begin
                w_tx_strobe     = 1'b1;
                w_guard_next    = LP_GUARD;
                w_tx_state_next = S_GUARD;
            end
            S_GUARD: begin
                if (r_guard <= LP_G1) begin
                    w_guard_next    = '0;
                    w_tx_state_next = S_IDLE;
                end else begin
                    w_guard_next = r_guard - LP_G1;
                end
            end
            default: w_tx_state_next = S_IDLE;
        endcase
    end

    assign w_tx_push = tx_wr && (r_tx_count != LP_FULL || w_tx_pop);

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr      <= '0;
            r_tx_rptr      <= '0;
            r_tx_count     <= '0;
            r_tx_overflow  <= 1'b0;
            r_uart_tx_data <= '0;
            r_tx_state     <= S_IDLE;
            r_guard        <= '0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_guard    <= w_guard_next;
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + LP_PTR1;
            end
            if (w_tx_pop) begin
                r_tx_rptr      <= r_tx_rptr + LP_PTR1;
                r_uart_tx_data <= r_tx_mem[r_tx_rptr];
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + LP_CNT1;
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - LP_CNT1;
            end
            if (tx_wr && !w_tx_push) begin
                r_tx_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_tx_overflow <= 1'b0;
            end
        end
    end

    assign w_rx_pop  = rx_rd && (r_rx_count != '0);
    assign w_rx_push = uart_rx_strobe && (r_rx_count != LP_FULL || w_rx_pop);
    assign w_rx_head = w_rx_pop ? r_rx_rptr + LP_PTR1 : r_rx_rptr;
    assign w_rx_left = w_rx_pop ? r_rx_count - LP_CNT1 : r_rx_count;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= uart_rx_data;
        end
    end

    // rx_data is the head after this edge; a byte landing in an empty FIFO bypasses the array
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wptr     <= '0;
            r_rx_rptr     <= '0;
            r_rx_count    <= '0;
            r_rx_overflow <= 1'b0;
            r_rx_data     <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + LP_PTR1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= w_rx_head;
            end
            if (w_rx_left != '0) begin
                r_rx_data <= r_rx_mem[w_rx_head];
            end else if (w_rx_push) begin
                r_rx_data <= uart_rx_data;
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + LP_CNT1;
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - LP_CNT1;
            end
            if (uart_rx_strobe && !w_rx_push) begin
                r_rx_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign tx_full        = (r_tx_count == LP_FULL);
    assign tx_count       = r_tx_count;
    assign tx_overflow    = r_tx_overflow;
    assign uart_tx_strobe = w_tx_strobe;
    assign uart_tx_data   = r_uart_tx_data;
    assign rx_data        = r_rx_data;
    assign rx_empty       = (r_rx_count == '0);
    assign rx_count       = r_rx_count;
    assign rx_overflow    = r_rx_overflow;

endmodule
